// File: rtl/uart_reg_responder.sv
// uart_reg_responder: parses SYNC/CMD/SRC/LEN/ADDR/DATA byte packets from a UART,
// performs register writes/reads and returns ack or read-response packets.
`default_nettype none

module uart_reg_responder #(
  parameter logic [7:0] SYNC_BYTE      = 8'h55,
  parameter logic [7:0] OWN_ID         = 8'h10,
  parameter int         TIMEOUT_CYCLES = 50000
) (
  input  logic       ipClk,
  input  logic       ipReset,
  input  logic [7:0] ipRxData,
  input  logic       ipRxValid,
  output logic [7:0] opTxData,
  output logic       opTxSend,
  input  logic       ipTxBusy,
  output logic       opWrEnable,
  output logic [7:0] opWrAddress,
  output logic [7:0] opWrData,
  output logic [7:0] opRdAddress,
  input  logic [7:0] ipRdData,
  output logic       opBusy
);

  localparam int                 TIMER_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [2:0]         HDR_LAST   = 3'd4;
  localparam logic [2:0]         TX_DATA    = 3'd5;

  typedef enum logic [3:0] {
    S_IDLE, S_CMD, S_SRC, S_LEN, S_ADDR, S_WDATA,
    S_RD_FETCH, S_RD_LATCH, S_TX_LOAD, S_TX_WAIT_HI, S_TX_WAIT_LO
  } state_t;

  state_t             state_q;
  logic               is_write_q;
  logic [7:0]         len_q;
  logic [7:0]         addr_q;
  logic [7:0]         idx_q;
  logic [7:0]         rd_byte_q;
  logic [2:0]         tx_cnt_q;
  logic [TIMER_W-1:0] timer_q;
  logic [7:0]         tx_byte;
  logic               rx_phase;

  // tx_cnt_q 0..4 walks the response header, 5 means a fetched register byte.
  always_comb begin
    tx_byte = rd_byte_q;
    case (tx_cnt_q)
      3'd0:    tx_byte = SYNC_BYTE;
      3'd1:    tx_byte = is_write_q ? 8'h03 : 8'h02;
      3'd2:    tx_byte = OWN_ID;
      3'd3:    tx_byte = len_q;
      3'd4:    tx_byte = addr_q;
      default: tx_byte = rd_byte_q;
    endcase
  end

  assign rx_phase = (state_q == S_CMD) || (state_q == S_SRC) || (state_q == S_LEN) ||
                    (state_q == S_ADDR) || (state_q == S_WDATA);
  assign opBusy   = (state_q != S_IDLE);

  always_ff @(posedge ipClk or negedge ipReset) begin
    if (!ipReset) begin
      state_q     <= S_IDLE;
      is_write_q  <= 1'b0;
      len_q       <= 8'h00;
      addr_q      <= 8'h00;
      idx_q       <= 8'h00;
      rd_byte_q   <= 8'h00;
      tx_cnt_q    <= 3'd0;
      timer_q     <= '0;
      opTxData    <= 8'h00;
      opTxSend    <= 1'b0;
      opWrEnable  <= 1'b0;
      opWrAddress <= 8'h00;
      opWrData    <= 8'h00;
      opRdAddress <= 8'h00;
    end else begin
      opTxSend   <= 1'b0;
      opWrEnable <= 1'b0;

      // Inter-byte timeout; the receive states below only act on ipRxValid.
      if (rx_phase) begin
        if (ipRxValid) begin
          timer_q <= '0;
        end else if (timer_q == TIMER_LAST) begin
          timer_q <= '0;
          state_q <= S_IDLE;
        end else begin
          timer_q <= timer_q + TIMER_W'(1);
        end
      end

      case (state_q)
        S_IDLE: begin
          if (ipRxValid && ipRxData == SYNC_BYTE) state_q <= S_CMD;
        end
        S_CMD: begin
          if (ipRxValid) begin
            is_write_q <= ipRxData[0];
            state_q    <= (ipRxData[7:1] == 7'd0) ? S_SRC : S_IDLE;
          end
        end
        S_SRC: begin
          if (ipRxValid) state_q <= S_LEN;
        end
        S_LEN: begin
          if (ipRxValid) begin
            len_q   <= ipRxData;
            state_q <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (ipRxValid) begin
            addr_q   <= ipRxData;
            idx_q    <= 8'h00;
            tx_cnt_q <= 3'd0;
            state_q  <= (is_write_q && len_q != 8'h00) ? S_WDATA : S_TX_LOAD;
          end
        end
        S_WDATA: begin
          if (ipRxValid) begin
            opWrEnable  <= 1'b1;
            opWrAddress <= addr_q + idx_q;
            opWrData    <= ipRxData;
            idx_q       <= idx_q + 8'd1;
            if (idx_q == len_q - 8'd1) state_q <= S_TX_LOAD;
          end
        end
        S_RD_FETCH: begin
          state_q <= S_RD_LATCH;
        end
        S_RD_LATCH: begin
          rd_byte_q <= ipRdData;
          idx_q     <= idx_q + 8'd1;
          state_q   <= S_TX_LOAD;
        end
        S_TX_LOAD: begin
          if (!ipTxBusy) begin
            opTxData <= tx_byte;
            opTxSend <= 1'b1;
            state_q  <= S_TX_WAIT_HI;
          end
        end
        S_TX_WAIT_HI: begin
          if (ipTxBusy) state_q <= S_TX_WAIT_LO;
        end
        S_TX_WAIT_LO: begin
          if (!ipTxBusy) begin
            if (tx_cnt_q < TX_DATA) tx_cnt_q <= tx_cnt_q + 3'd1;
            if (tx_cnt_q < HDR_LAST) begin
              state_q <= S_TX_LOAD;
            end else if (is_write_q || idx_q == len_q) begin
              state_q <= S_IDLE;
            end else begin
              // Address is presented for the whole fetch cycle so a synchronous
              // register file has its data ready when RD_LATCH samples it.
              opRdAddress <= addr_q + idx_q;
              state_q     <= S_RD_FETCH;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/uart_reg_responder.md
Name: uart_reg_responder

Overview:
Packet-level responder that sits between the UART receiver/transmitter pair and the register file of the Test top level. It parses incoming UART byte packets (SYNC, Command, Source, Length, Address, Data...), executes register writes or reads, and returns an acknowledge or read-response packet through the UART transmitter. It is the slave-side counterpart of the host/bench packet sender.

Parameters:
SYNC_BYTE, 8'h55, packet start marker.
OWN_ID, 8'h10, value placed in the Source field of every response.
TIMEOUT_CYCLES, 50000, maximum ipClk cycles between received bytes of one packet before the packet is abandoned.

Ports:
ipClk  input  1  system clock
ipReset  input  1  asynchronous, active-low reset
ipRxData  input  8  byte from UART receiver
ipRxValid  input  1  one-cycle strobe, ipRxData valid
opTxData  output  8  byte to UART transmitter
opTxSend  output  1  one-cycle request to transmit opTxData
ipTxBusy  input  1  UART transmitter busy
opWrEnable  output  1  one-cycle register write strobe
opWrAddress  output  8  register write address
opWrData  output  8  register write data
opRdAddress  output  8  register read address
ipRdData  input  8  register read data, valid 1 cycle after opRdAddress
opBusy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (ipReset low, async): all outputs 0, state IDLE, counters 0.
- Packet in: SYNC_BYTE, CMD, SRC, LEN, ADDR, then LEN data bytes (write only). CMD 8'h00 = read, 8'h01 = write; any other CMD -> discard, back to IDLE after the CMD byte.
- States: IDLE, CMD, SRC, LEN, ADDR, WDATA, RD_FETCH, RD_LATCH, TX_LOAD, TX_WAIT_HI, TX_WAIT_LO.
- IDLE: bytes other than SYNC_BYTE ignored. SYNC_BYTE -> CMD.
- CMD/SRC/LEN/ADDR: each consumes one ipRxValid byte; fields latched.
- Write: each WDATA byte -> opWrEnable high exactly one cycle, the cycle after ipRxValid, with opWrAddress = ADDR + index (8-bit, wraps 8'hFF -> 8'h00), opWrData = byte. After LEN bytes -> ack packet.
- LEN = 0 write: no strobes, ack sent immediately after ADDR.
- Ack packet: SYNC_BYTE, 8'h03, OWN_ID, LEN, ADDR (5 bytes).
- Read: after ADDR, response header SYNC_BYTE, 8'h02, OWN_ID, LEN, ADDR is sent, then for each of LEN registers: RD_FETCH drives opRdAddress = ADDR + index (wrapping), RD_LATCH captures ipRdData the next cycle, then byte is transmitted. LEN = 0 -> header only.
- Tx handshake per byte: TX_LOAD waits for ipTxBusy low, drives opTxData and opTxSend high for one cycle; TX_WAIT_HI waits for ipTxBusy high; TX_WAIT_LO waits for ipTxBusy low; next byte. opTxData held stable until ipTxBusy goes high.
- ipRxValid bytes arriving while transmitting or fetching are dropped (no queueing).
- Timeout: in CMD..WDATA, counter cleared on each ipRxValid; reaching TIMEOUT_CYCLES -> IDLE, no writes after that point, no response. Writes already strobed stay done.
- SYNC_BYTE value inside a packet is data, not a restart.
- Reset mid-packet or mid-transmit: immediate abort, opTxSend/opWrEnable low; no resumption.

Test Plan:
- Write: rx 55 01 AA 04 02 03 04 05 06 -> opWrEnable pulses at addr 02..05 with data 03..06, then tx 55 03 10 04 02.
- Read: registers 02..05 preloaded 03..06; rx 55 00 AA 04 02 -> tx 55 02 10 04 02 03 04 05 06, opRdAddress steps 02..05.
- Wrap: write LEN 2 at ADDR FF -> writes at FF then 00; read LEN 2 at FF returns both.
- Bad/garbage: rx 12 34 55 07 -> no writes, no tx, opBusy low after 07; following valid packet handled normally.
- Timeout: rx 55 01 AA 03 02 03 then silence > TIMEOUT_CYCLES -> one write only, no ack, opBusy low; LEN 0 write -> ack only, no strobes.
- Reset during read response after 3 tx bytes -> opTxSend and opBusy go low asynchronously, no further bytes sent.
